calc_rx_sampler: RTL and testbench
==================================

# calc_rx_sampler

Serial receive front end of the calculator's input path. Oversamples the asynchronous `rxd` line, finds 8N1 frames, and drives the 10-bit frame shift register through its load, shift-enable and shift-input controls. After the 10th shift it reads the register's parallel output back, checks framing, and presents the data byte to the calculator core over a valid/ready handshake.

## Interface
- `BAUD_DIV`, 27: clk cycles per oversample tick; 16 ticks per bit; legal range 2..4095.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rxd`  in  1  asynchronous serial line; idle high.
- `frame`  in  10  parallel output of the frame shift register. Bit 9 receives the shift input; the register shifts toward bit 0.
- `ld3ff`  out  1  one-cycle pulse that presets the frame register to 10'h3ff.
- `sh_en`  out  1  one-cycle shift strobe.
- `sh_si`  out  1  sampled bit value, valid while `sh_en` is high.
- `data`  out  8  received byte; stable while `valid` is high.
- `valid`  out  1  byte available.
- `ready`  in  1  consumer accepts the byte on `valid & ready`.
- `frame_err`  out  1  one-cycle pulse when a frame has a bad start or stop bit.
- `overrun`  out  1  one-cycle pulse when a good frame is dropped because the previous byte is still held.

## Operation
- `rxd` passes through a 2-flop synchronizer to give `rxd_s`. All decisions use `rxd_s`.
- **Prescaler.** Counts 0..BAUD_DIV-1 and emits `tick` at BAUD_DIV-1. A 4-bit sample counter advances on each tick. Both counters clear on start detection.
- **States:** IDLE, START, DATA, STOP, CHECK.
- **IDLE.** `armed` sets when `rxd_s` = 1. When `armed` and `rxd_s` = 0:
  - pulse `ld3ff`;
  - clear the counters;
  - go to START.
- **Decision point.** A bit is decided on the tick where the sample counter equals 9.
- **START.** At the decision point:
  - if the sampled value is 1, treat it as a false start: return to IDLE with no `sh_en`;
  - otherwise pulse `sh_en` with `sh_si` = 0 and go to DATA.
- **DATA.** Each bit is decided 16 ticks after the previous one, and each decision pulses `sh_en` with the sample. Data is LSB first. After 8 shifts, go to STOP.
- **STOP.** Decide the bit 16 ticks later and pulse `sh_en`. This is the 10th shift. Go to CHECK.
- **CHECK** (one cycle). The frame is good when `frame[0]` = 0 and `frame[9]` = 1.
  - Good frame, holding register free (or `valid & ready` this cycle): load `data` = `frame[8:1]` and set `valid`.
  - Good frame, `valid` high and `ready` low: pulse `overrun`; the old byte is kept.
  - Bad frame: pulse `frame_err`; `data` and `valid` are unchanged.
  - In all cases, clear `armed` and go to IDLE. A stuck-low line (break) therefore never re-triggers until it returns high.
- **Handshake.** `valid` clears on `valid & ready` unless it is reloaded in the same cycle.
- **Reset.** Any `rst` cycle, including mid-frame, forces:
  - state to IDLE and `armed` to 0;
  - all counters to 0;
  - every output to 0 (`ld3ff`, `sh_en`, `sh_si`, `data` = 8'h00, `valid`, `frame_err`, `overrun`).
  The partial frame is discarded.

## Timing
- `rxd` to `rxd_s`: 2 cycles.
- The `ld3ff` pulse occurs in the cycle after `rxd_s` is first seen low.
- Bit decisions are 16·BAUD_DIV cycles apart. The start-bit decision falls 10·BAUD_DIV cycles after `ld3ff`.
- The frame register updates on the edge that ends the `sh_en` cycle. CHECK is the next cycle. `valid`, `frame_err` and `overrun` are registered and appear 2 cycles after the stop-bit `sh_en`.
- `ld3ff` and `sh_en` are never high together.
- Exactly 10 `sh_en` pulses occur per accepted start, and none after a false start.

## Configuration
- `RX_MAJORITY_EN` defined: the decided value is the majority of `rxd_s` captured at sample counts 7, 8 and 9.
- Not defined: the decided value is `rxd_s` captured at count 8.
- The decision still happens at count 9 in both cases, so cycle timing is identical.

## Structure
- Package `calc_rx_pkg` holds:
  - the state enum;
  - `OVS` = 16;
  - `FRAME_W` = 10;
  - sample-index constants 7, 8, 9.
- Sub-module `rx_baud_tick` contains the prescaler and the 16x sample counter. It has clear and enable inputs and `tick` and `scnt[3:0]` outputs.

## Test plan
- All cases run with BAUD_DIV = 4, i.e. 64 cycles per bit. The bench models the 10-bit frame register.
- **Good frame.** Send 0xA5 with `ready` = 1:
  - 1 `ld3ff`;
  - `sh_si` sequence 0,1,0,1,0,0,1,0,1,1;
  - `data` = 8'hA5;
  - `valid` high for 1 cycle.
- **False start.** Low glitch of 20 cycles, then high: no `sh_en`, state returns to IDLE, and the next 0x3C frame is received correctly.
- **Break.** Send 0x3C with stop bit 0, then hold the line low 200 cycles:
  - 1 `frame_err` pulse and `valid` stays 0;
  - no further `ld3ff` until the line goes high.
- **Overrun.** Send 0x11 then 0x22 with `ready` = 0:
  - `data` stays 8'h11 and `overrun` pulses once;
  - raising `ready` drops `valid` after 1 cycle.
- **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 4:
  - all outputs read 0 on the next cycle;
  - a following 0x5A frame is received correctly.
- **Majority vote.** Force a 4-cycle low pulse centred on sample 8 of bit 0 of 0xFF:
  - with `RX_MAJORITY_EN`, `data` = 8'hFF;
  - without it, `data` = 8'hFE.

Source files
------------

// File: rtl/calc_rx_pkg.sv
// Shared types and constants for the calculator serial receive front end.
package calc_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CHECK
  } rx_state_e;

  localparam int OVS     = 16;
  localparam int FRAME_W = 10;

  // Sample-counter positions used to decide a bit (mid-bit and its neighbours).
  localparam logic [3:0] SMP_EARLY = 4'd7;
  localparam logic [3:0] SMP_MID   = 4'd8;
  localparam logic [3:0] SMP_LATE  = 4'd9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/calc_rx_if.sv
// Frame-register control and byte-delivery signals between the sampler and its neighbours.
interface calc_rx_if;
  import calc_rx_pkg::*;

  logic               ld3ff;
  logic               sh_en;
  logic               sh_si;
  logic [FRAME_W-1:0] frame;
  logic [7:0]         data;
  logic               valid;
  logic               ready;
  logic               frame_err;
  logic               overrun;

  // Byte handshake: data is held stable while valid is high; the byte is
  // consumed on a cycle with valid & ready, after which valid drops unless
  // a new byte is loaded in that same cycle.
  modport master (
    output ld3ff, sh_en, sh_si, data, valid, frame_err, overrun,
    input  frame, ready
  );

  modport slave (
    input  ld3ff, sh_en, sh_si, data, valid, frame_err, overrun,
    output frame, ready
  );

endinterface

// File: rtl/calc_rx_baud_tick.sv
// Baud prescaler plus 16x oversample counter; both restart from zero on clr.
module rx_baud_tick
  import calc_rx_pkg::*;
#(
  parameter int BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic       tick,
  output logic [3:0] scnt
);

  localparam logic [11:0] PMAX = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  SMAX = 4'(OVS - 1);

  logic [11:0] pcnt_q, pcnt_d;
  logic [3:0]  scnt_q, scnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    scnt_d = scnt_q;
    tick   = 1'b0;
    if (clr) begin
      pcnt_d = '0;
      scnt_d = '0;
    end else if (en) begin
      if (pcnt_q == PMAX) begin
        pcnt_d = '0;
        tick   = 1'b1;
        scnt_d = (scnt_q == SMAX) ? 4'd0 : scnt_q + 4'd1;
      end else begin
        pcnt_d = pcnt_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign scnt = scnt_q;

endmodule

// File: rtl/calc_rx_sampler.sv
// 8N1 receive sampler driving an external 10-bit frame shift register.
// RX_MAJORITY_EN: decide each bit by 2-of-3 vote over sample counts 7/8/9.
module calc_rx_sampler
  import calc_rx_pkg::*;
#(
  parameter int BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  calc_rx_if.master  bus,
  output rx_state_e  dbg_state
);

  rx_state_e   state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic        armed_q, armed_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic        smp_mid_q, smp_mid_d;
  logic        ld3ff_q, ld3ff_d;
  logic        sh_en_q, sh_en_d;
  logic        sh_si_q, sh_si_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  logic        rxd_s;
  logic        tick;
  logic [3:0]  scnt;
  logic        tick_clr;
  logic        decide;
  logic        bit_val;
  logic        frame_ok;

  assign rxd_s    = sync_q[1];
  assign decide   = tick && (scnt == SMP_LATE);
  assign frame_ok = !bus.frame[0] && bus.frame[FRAME_W-1];

  rx_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (state_q inside {S_START, S_DATA, S_STOP}),
    .tick (tick),
    .scnt (scnt)
  );

`ifdef RX_MAJORITY_EN
  logic smp_early_q, smp_early_d;
  assign smp_early_d = (tick && scnt == SMP_EARLY) ? rxd_s : smp_early_q;
  // The count-9 sample is the live synchronized value at the decision tick.
  assign bit_val = maj3(smp_early_q, smp_mid_q, rxd_s);
  always_ff @(posedge clk) begin
    if (rst) smp_early_q <= 1'b0;
    else     smp_early_q <= smp_early_d;
  end
`else
  assign bit_val = smp_mid_q;
`endif

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rxd};
    armed_d     = armed_q;
    bcnt_d      = bcnt_q;
    smp_mid_d   = (tick && scnt == SMP_MID) ? rxd_s : smp_mid_q;
    ld3ff_d     = 1'b0;
    sh_en_d     = 1'b0;
    sh_si_d     = 1'b0;
    data_d      = data_q;
    valid_d     = valid_q & ~bus.ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    tick_clr    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rxd_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          ld3ff_d  = 1'b1;
          tick_clr = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (decide) begin
          if (bit_val) begin
            state_d = S_IDLE;
          end else begin
            sh_en_d = 1'b1;
            bcnt_d  = 4'd0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (decide) begin
          sh_en_d = 1'b1;
          sh_si_d = bit_val;
          bcnt_d  = bcnt_q + 4'd1;
          if (bcnt_q == 4'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // bcnt 9 marks the stop shift as issued; wait one cycle for the register.
        if (bcnt_q == 4'd9) begin
          state_d = S_CHECK;
        end else if (decide) begin
          sh_en_d = 1'b1;
          sh_si_d = bit_val;
          bcnt_d  = 4'd9;
        end
      end
      S_CHECK: begin
        armed_d = 1'b0;
        state_d = S_IDLE;
        if (!frame_ok) begin
          frame_err_d = 1'b1;
        end else if (!valid_q || bus.ready) begin
          data_d  = bus.frame[8:1];
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      armed_q     <= 1'b0;
      bcnt_q      <= 4'd0;
      smp_mid_q   <= 1'b0;
      ld3ff_q     <= 1'b0;
      sh_en_q     <= 1'b0;
      sh_si_q     <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      armed_q     <= armed_d;
      bcnt_q      <= bcnt_d;
      smp_mid_q   <= smp_mid_d;
      ld3ff_q     <= ld3ff_d;
      sh_en_q     <= sh_en_d;
      sh_si_q     <= sh_si_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.ld3ff     = ld3ff_q;
  assign bus.sh_en     = sh_en_q;
  assign bus.sh_si     = sh_si_q;
  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_calc_rx_sampler.sv
// Directed bench for calc_rx_sampler at BAUD_DIV=4 with a per-cycle timeline model.
module tb_calc_rx_sampler;
  import calc_rx_pkg::*;

  localparam int BD    = 4;
  localparam int BIT_T = 16 * BD;
  localparam int DEPTH = 16384;
`ifdef RX_MAJORITY_EN
  localparam bit MAJ_BIT = 1'b1;
`else
  localparam bit MAJ_BIT = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      rxd = 1'b1;
  rx_state_e dbg_state;
  calc_rx_if bus();

  calc_rx_sampler #(.BAUD_DIV(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- frame shift register model ----------------
  logic [9:0] frame_q = 10'h000;
  always @(posedge clk) begin
    if (bus.ld3ff)      frame_q <= 10'h3ff;
    else if (bus.sh_en) frame_q <= {bus.sh_si, frame_q[9:1]};
  end
  assign bus.frame = frame_q;

  // ---------------- expected timeline and scoreboard ----------------
  bit         exp_ld  [DEPTH];
  bit         exp_sh  [DEPTH];
  bit         exp_si  [DEPTH];
  bit         exp_arr [DEPTH];
  bit         exp_fe  [DEPTH];
  logic [7:0] exp_q[$];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_err  = 0;
  int n_ld   = 0;
  int n_sh   = 0;
  int n_vcyc = 0;
  int n_fe   = 0;
  int n_ovr  = 0;
  logic [9:0] si_hist = 10'h000;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs after each rising edge versus the timeline plus a byte-holding model.
  initial begin : compare
    logic        mv;
    logic [7:0]  md;
    logic [7:0]  nb;
    logic        el, es, esi, ef, eo;
    logic [13:0] exp_v, act_v;
    mv = 1'b0;
    md = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      eo = 1'b0;
      if (rst) begin
        mv = 1'b0;
        md = 8'h00;
      end else if (exp_arr[cyc]) begin
        nb = 8'h00;
        if (exp_q.size() > 0) nb = exp_q.pop_front();
        if (!mv || bus.ready) begin
          mv = 1'b1;
          md = nb;
        end else begin
          eo = 1'b1;
        end
      end else if (bus.ready) begin
        mv = 1'b0;
      end
      el  = !rst && exp_ld[cyc];
      es  = !rst && exp_sh[cyc];
      esi = es && exp_si[cyc];
      ef  = !rst && exp_fe[cyc];
      exp_v = {el, es, esi, mv, md, ef, eo};
      act_v = {bus.ld3ff, bus.sh_en, bus.sh_si & es, bus.valid, bus.data,
               bus.frame_err, bus.overrun};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL outputs@%0d: got ld=%b sh=%b si=%b v=%b d=%h fe=%b ov=%b expected ld=%b sh=%b si=%b v=%b d=%h fe=%b ov=%b",
                 cyc, act_v[13], act_v[12], act_v[11], act_v[10], act_v[9:2], act_v[1], act_v[0],
                 exp_v[13], exp_v[12], exp_v[11], exp_v[10], exp_v[9:2], exp_v[1], exp_v[0]);
      end
      if (bus.ld3ff) n_ld++;
      if (bus.sh_en) begin
        n_sh++;
        si_hist = {si_hist[8:0], bus.sh_si};
      end
      if (bus.valid)     n_vcyc++;
      if (bus.frame_err) n_fe++;
      if (bus.overrun)   n_ovr++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_high(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    chk(name, int'({bus.ld3ff, bus.sh_en, bus.sh_si, bus.data, bus.valid,
                    bus.frame_err, bus.overrun}), 0);
  endtask

  // Drives one 8N1 frame starting at this falling edge. Expected events are
  // placed on the timeline: ld3ff 3 cycles after the line falls, shifts at
  // 40 cycles + 64 per bit after that, result 2 cycles after the stop shift.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input bit glitch, input int abort_at);
    logic [9:0] bits;
    logic [9:0] dec;
    int         n;
    bits = {stop, b, 1'b0};
    dec  = bits;
    if (glitch) dec[1] = MAJ_BIT;
    n = cyc;
    exp_ld[n + 3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      exp_sh[n + 3 + 10 * BD + BIT_T * k] = 1'b1;
      exp_si[n + 3 + 10 * BD + BIT_T * k] = dec[k];
    end
    if (dec[9]) begin
      exp_arr[n + 3 + 10 * BD + BIT_T * 9 + 2] = 1'b1;
      exp_q.push_back(dec[8:1]);
    end else begin
      exp_fe[n + 3 + 10 * BD + BIT_T * 9 + 2] = 1'b1;
    end
    for (int j = 0; j < 10 * BIT_T; j++) begin
      if (j == abort_at) begin
        for (int i = cyc + 1; i < DEPTH; i++) begin
          exp_ld[i]  = 1'b0;
          exp_sh[i]  = 1'b0;
          exp_arr[i] = 1'b0;
          exp_fe[i]  = 1'b0;
        end
        if (dec[9]) void'(exp_q.pop_back());
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        chk_zero("mid_frame_reset_outputs");
        rst = 1'b0;
        return;
      end
      rxd = bits[j / BIT_T];
      if (glitch && j >= BIT_T + 34 && j <= BIT_T + 37) rxd = 1'b0;
      @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int s_ld, s_sh, s_v, s_fe, s_ovr, n;
    bus.ready = 1'b1;
    repeat (4) @(negedge clk);
    chk_zero("reset_outputs");
    chk("reset_state", int'(dbg_state), int'(S_IDLE));
    rst = 1'b0;
    idle_high(20);

    // Good frame 0xA5
    s_ld = n_ld; s_sh = n_sh; s_v = n_vcyc;
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    idle_high(30);
    chk("a5_ld3ff_count", n_ld - s_ld, 1);
    chk("a5_shift_count", n_sh - s_sh, 10);
    chk("a5_si_sequence", int'(si_hist), 'h14B);
    chk("a5_data", int'(bus.data), 'hA5);
    chk("a5_valid_cycles", n_vcyc - s_v, 1);

    // False start: 20-cycle low glitch
    s_ld = n_ld; s_sh = n_sh;
    n = cyc;
    exp_ld[n + 3] = 1'b1;
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    idle_high(80);
    chk("fs_ld3ff_count", n_ld - s_ld, 1);
    chk("fs_shift_count", n_sh - s_sh, 0);
    chk("fs_state_idle", int'(dbg_state), int'(S_IDLE));
    send_frame(8'h3C, 1'b1, 1'b0, -1);
    idle_high(30);
    chk("fs_next_data", int'(bus.data), 'h3C);

    // Break: bad stop bit, then line held low
    s_ld = n_ld; s_fe = n_fe; s_v = n_vcyc;
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    repeat (200) @(negedge clk);
    chk("brk_frame_err_count", n_fe - s_fe, 1);
    chk("brk_valid_cycles", n_vcyc - s_v, 0);
    chk("brk_no_retrigger", n_ld - s_ld, 1);
    chk("brk_data_kept", int'(bus.data), 'h3C);
    idle_high(40);

    // Overrun with consumer stalled
    bus.ready = 1'b0;
    s_ovr = n_ovr;
    send_frame(8'h11, 1'b1, 1'b0, -1);
    idle_high(20);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    idle_high(30);
    chk("ovr_data_kept", int'(bus.data), 'h11);
    chk("ovr_pulse_count", n_ovr - s_ovr, 1);
    chk("ovr_valid_held", int'(bus.valid), 1);
    bus.ready = 1'b1;
    @(negedge clk);
    chk("ovr_valid_dropped", int'(bus.valid), 0);
    idle_high(20);

    // Reset during data bit 4, then a clean frame
    send_frame(8'h96, 1'b1, 1'b0, 5 * BIT_T + 30);
    chk("rst_state_idle", int'(dbg_state), int'(S_IDLE));
    idle_high(40);
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    idle_high(30);
    chk("rst_next_data", int'(bus.data), 'h5A);

    // Short low pulse around the mid sample of data bit 0
    send_frame(8'hFF, 1'b1, 1'b1, -1);
    idle_high(30);
`ifdef RX_MAJORITY_EN
    chk("vote_data", int'(bus.data), 'hFF);
`else
    chk("vote_data", int'(bus.data), 'hFE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
